// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types for the two-channel memory port arbiter.
//   NUM_CH  : number of requesting channels sharing the memory port
//   state_t : arbiter FSM state (IDLE -> ISSUE -> WAIT -> DONE)
//   op_t    : operation captured at grant time (read or write)
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    localparam int NUM_CH = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the accelerator-side request/response lanes and the single memory
// port handled by mem_port_arbiter.
//   req_oe/req_we/req_addr/req_wdata/req_size : per-channel requests (2 lanes)
//   rsp_rdata/rsp_rdy                         : per-channel responses
//   mem_oe/mem_we/mem_addr/mem_wdata/mem_size : memory command
//   mem_rdata/mem_rdy                         : memory completion
// Handshake: a channel raises req_oe or req_we (the "valid") and holds it with
// stable address/data until its rsp_rdy pulses for one cycle (the "ready");
// likewise the arbiter holds mem_oe/mem_we and all mem_* fields stable until
// the memory returns mem_rdy, and drops the enable the following cycle.
// Modports: slave = the arbiter, master = the environment (requesters+memory).
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8,
    parameter int SIZE_W = 4
);
    logic [1:0]          req_oe;
    logic [1:0]          req_we;
    logic [2*ADDR_W-1:0] req_addr;
    logic [2*DATA_W-1:0] req_wdata;
    logic [2*SIZE_W-1:0] req_size;
    logic [2*DATA_W-1:0] rsp_rdata;
    logic [1:0]          rsp_rdy;
    logic                mem_oe;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [SIZE_W-1:0]   mem_size;
    logic [DATA_W-1:0]   mem_rdata;
    logic                mem_rdy;

    modport slave (
        input  req_oe, req_we, req_addr, req_wdata, req_size, mem_rdata, mem_rdy,
        output rsp_rdata, rsp_rdy, mem_oe, mem_we, mem_addr, mem_wdata, mem_size
    );

    modport master (
        output req_oe, req_we, req_addr, req_wdata, req_size, mem_rdata, mem_rdy,
        input  rsp_rdata, rsp_rdy, mem_oe, mem_we, mem_addr, mem_wdata, mem_size
    );
endinterface

// File: rtl/mem_port_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Combinational two-way round-robin picker.
//   eligible[1:0] : channels currently requesting
//   rr_last       : channel served most recently
//   grant_valid   : at least one channel eligible
//   grant_idx     : chosen channel; on a tie the one not served last wins
// -----------------------------------------------------------------------------
module rr_arb2 (
    input  logic [1:0] eligible,
    input  logic       rr_last,
    output logic       grant_valid,
    output logic       grant_idx
);
    always_comb begin
        grant_valid = |eligible;
        grant_idx   = 1'b0;
        if (eligible == 2'b11) begin
            grant_idx = ~rr_last;
        end else if (eligible[1]) begin
            grant_idx = 1'b1;
        end
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Serialises read/write requests from two channels onto one memory port, one
// transaction outstanding at a time, and returns read data plus a one-cycle
// completion pulse to the requesting channel.
// Ports:
//   clock     : rising-edge clock
//   reset     : asynchronous active-low reset
//   bus       : mem_port_arbiter_if.slave (request lanes, responses, memory port)
//   proto_err : sticky protocol error (oe&we together, or request dropped
//               while its transaction is in flight); cleared only by reset
//   grant_cnt : {ch1, ch0} saturating completed-transaction counters
//   state_dbg : current FSM state
// Optional build macro MEM_ARB_STATS_EN: when defined, grant_cnt counters are
// built; otherwise grant_cnt is constant zero and no counter flops exist.
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8,
    parameter int SIZE_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    mem_port_arbiter_if.slave    bus,
    output logic                 proto_err,
    output logic [2*CNT_W-1:0]   grant_cnt,
    output state_t               state_dbg
);

    state_t            state_q,   state_d;
    logic              grant_q,   grant_d;
    op_t               op_q,      op_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic [DATA_W-1:0] wdata_q,   wdata_d;
    logic [SIZE_W-1:0] size_q,    size_d;
    logic [DATA_W-1:0] rdata_q,   rdata_d;
    logic              rr_last_q, rr_last_d;
    logic              proto_err_q, proto_err_d;

    logic [1:0] req_any;
    logic [1:0] req_both;
    logic [1:0] elig;
    logic       pick_valid;
    logic       pick_idx;
    logic [1:0] rsp_rdy_w;

    assign req_any  = bus.req_oe | bus.req_we;
    assign req_both = bus.req_oe & bus.req_we;

    // In DONE the just-served channel is still winding down its request, so it
    // is masked out; only the other channel can be picked up back-to-back.
    always_comb begin
        elig = req_any;
        if (state_q == DONE) begin
            elig[grant_q] = 1'b0;
        end
    end

    rr_arb2 u_rr_arb2 (
        .eligible    (elig),
        .rr_last     (rr_last_q),
        .grant_valid (pick_valid),
        .grant_idx   (pick_idx)
    );

    // Next-state and capture logic
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        op_d        = op_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        size_d      = size_q;
        rdata_d     = rdata_q;
        rr_last_d   = rr_last_q;
        proto_err_d = proto_err_q;

        case (state_q)
            IDLE, DONE: begin
                if ((req_both & elig) != 2'b00) begin
                    proto_err_d = 1'b1;
                end
                if (pick_valid) begin
                    grant_d = pick_idx;
                    // oe wins when both strobes are set: treated as a read.
                    op_d    = bus.req_oe[pick_idx] ? OP_RD : OP_WR;
                    addr_d  = pick_idx ? bus.req_addr[2*ADDR_W-1:ADDR_W]
                                       : bus.req_addr[ADDR_W-1:0];
                    wdata_d = pick_idx ? bus.req_wdata[2*DATA_W-1:DATA_W]
                                       : bus.req_wdata[DATA_W-1:0];
                    size_d  = pick_idx ? bus.req_size[2*SIZE_W-1:SIZE_W]
                                       : bus.req_size[SIZE_W-1:0];
                    state_d = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                if (!req_any[grant_q]) begin
                    proto_err_d = 1'b1;
                end
                state_d = WAIT;
            end
            WAIT: begin
                if (!req_any[grant_q]) begin
                    proto_err_d = 1'b1;
                end
                if (bus.mem_rdy) begin
                    rdata_d   = (op_q == OP_RD) ? bus.mem_rdata : '0;
                    rr_last_d = grant_q;
                    state_d   = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            grant_q     <= 1'b0;
            op_q        <= OP_RD;
            addr_q      <= '0;
            wdata_q     <= '0;
            size_q      <= '0;
            rdata_q     <= '0;
            rr_last_q   <= 1'b1;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            size_q      <= size_d;
            rdata_q     <= rdata_d;
            rr_last_q   <= rr_last_d;
            proto_err_q <= proto_err_d;
        end
    end

    // Memory command is a pure function of registered state, so it cannot
    // move while the FSM sits in WAIT.
    assign bus.mem_oe    = ((state_q == ISSUE) || (state_q == WAIT)) && (op_q == OP_RD);
    assign bus.mem_we    = ((state_q == ISSUE) || (state_q == WAIT)) && (op_q == OP_WR);
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_size  = size_q;

    always_comb begin
        rsp_rdy_w     = 2'b00;
        bus.rsp_rdata = '0;
        if (state_q == DONE) begin
            rsp_rdy_w[grant_q] = 1'b1;
            if (grant_q) begin
                bus.rsp_rdata[2*DATA_W-1:DATA_W] = rdata_q;
            end else begin
                bus.rsp_rdata[DATA_W-1:0] = rdata_q;
            end
        end
    end

    assign bus.rsp_rdy = rsp_rdy_w;
    assign proto_err   = proto_err_q;
    assign state_dbg   = state_q;

`ifdef MEM_ARB_STATS_EN
    logic [CNT_W-1:0] cnt_q [NUM_CH];
    logic [CNT_W-1:0] cnt_d [NUM_CH];

    // Saturating per-channel completion counters
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            cnt_d[c] = cnt_q[c];
            if (rsp_rdy_w[c] && (cnt_q[c] != {CNT_W{1'b1}})) begin
                cnt_d[c] = cnt_q[c] + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                cnt_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                cnt_q[c] <= cnt_d[c];
            end
        end
    end

    assign grant_cnt = {cnt_q[1], cnt_q[0]};
`else
    assign grant_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter: a behavioural memory with programmable
// latency answers the memory port; one initial block walks through reset,
// single read, contention, fairness, protocol errors and reset mid-access.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 8;
    localparam int SIZE_W = 4;
    localparam int CNT_W  = 16;

    logic                clock;
    logic                reset;
    logic                proto_err;
    logic [2*CNT_W-1:0]  grant_cnt;
    state_t              state_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SIZE_W(SIZE_W)) bus ();

    mem_port_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .SIZE_W (SIZE_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .proto_err (proto_err),
        .grant_cnt (grant_cnt),
        .state_dbg (state_dbg)
    );

    // ---------------- clock ----------------
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // ---------------- memory model ----------------
    // mem_rdy rises mem_lat cycles after the memory first samples the enable.
    logic [7:0] mem_arr [128] = '{5: 8'hA5, default: 8'h00};
    int mem_lat = 1;
    int mem_cnt = 0;

    always @(negedge clock or negedge reset) begin
        if (!reset) begin
            bus.mem_rdy   = 1'b0;
            bus.mem_rdata = '0;
            mem_cnt       = 0;
        end else if (bus.mem_rdy) begin
            bus.mem_rdy   = 1'b0;
            bus.mem_rdata = '0;
            mem_cnt       = 0;
        end else if (bus.mem_oe || bus.mem_we) begin
            mem_cnt++;
            if (mem_cnt == mem_lat + 1) begin
                bus.mem_rdy = 1'b1;
                if (bus.mem_oe) begin
                    bus.mem_rdata = mem_arr[bus.mem_addr];
                end else begin
                    mem_arr[bus.mem_addr] = bus.mem_wdata;
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_req();
        bus.req_oe    = 2'b00;
        bus.req_we    = 2'b00;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_size  = '0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        #2 reset = 1'b0;
        @(negedge clock);
        #2 reset = 1'b1;
    endtask

    // Waits (bounded) for any rsp_rdy pulse; returns zeros on timeout.
    task automatic wait_rsp(input int budget, output logic [1:0] seen, output logic [15:0] data);
        seen = 2'b00;
        data = '0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (bus.rsp_rdy != 2'b00) begin
                seen = bus.rsp_rdy;
                data = bus.rsp_rdata;
                break;
            end
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [1:0]  seen;
        logic [15:0] data;
        int          extra;

        reset = 1'b0;
        clr_req();

        // 1: reset with random inputs -> all outputs zero
        for (int i = 0; i < 4; i++) begin
            bus.req_oe    = 2'($urandom_range(0, 3));
            bus.req_we    = 2'($urandom_range(0, 3));
            bus.req_addr  = 14'($urandom());
            bus.req_wdata = 16'($urandom());
            bus.req_size  = 8'($urandom());
            @(negedge clock);
            check("rst_mem_cmd", {bus.mem_oe, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_size}, '0);
            check("rst_rsp", {bus.rsp_rdy, bus.rsp_rdata}, '0);
            check("rst_err_cnt", {proto_err, grant_cnt}, '0);
            check("rst_state", state_dbg, IDLE);
        end
        clr_req();
        #2 reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            check("idle_no_mem", {bus.mem_oe, bus.mem_we}, 2'b00);
        end

        // 2: single read ch0 @0x05, latency 2
        mem_lat = 2;
        @(negedge clock);
        bus.req_oe   = 2'b01;
        bus.req_addr = {7'd0, 7'h05};
        bus.req_size = {4'd0, 4'd8};
        @(negedge clock);
        check("rd_issue_oe", {bus.mem_oe, bus.mem_we}, 2'b10);
        check("rd_issue_addr", bus.mem_addr, 7'h05);
        check("rd_issue_size", bus.mem_size, 4'd8);
        check("rd_issue_state", state_dbg, ISSUE);
        @(negedge clock);
        check("rd_wait_oe1", bus.mem_oe, 1'b1);
        @(negedge clock);
        check("rd_wait_oe2", bus.mem_oe, 1'b1);
        check("rd_wait_rsp", bus.rsp_rdy, 2'b00);
        @(negedge clock);
        check("rd_rsp_rdy", bus.rsp_rdy, 2'b01);
        check("rd_rsp_data", bus.rsp_rdata, 16'h00A5);
        check("rd_done_oe", bus.mem_oe, 1'b0);
        clr_req();
        @(negedge clock);
        check("rd_after_rdy", bus.rsp_rdy, 2'b00);
        check("rd_after_state", state_dbg, IDLE);

        // 3: contention from fresh reset: ch0 read first, then ch1 write
        do_reset();
        mem_lat = 1;
        @(negedge clock);
        bus.req_oe    = 2'b01;
        bus.req_we    = 2'b10;
        bus.req_addr  = {7'h02, 7'h05};
        bus.req_wdata = {8'h3C, 8'h00};
        bus.req_size  = {4'd8, 4'd8};
        wait_rsp(20, seen, data);
        check("cont_first", seen, 2'b01);
        check("cont_first_data", data, 16'h00A5);
        bus.req_oe = 2'b00;
        wait_rsp(20, seen, data);
        check("cont_second", seen, 2'b10);
        check("cont_second_data", data, 16'h0000);
        clr_req();
        check("cont_mem_wr", mem_arr[2], 8'h3C);
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (bus.rsp_rdy != 2'b00) extra++;
        end
        check("cont_no_extra", extra, 0);
        check("cont_no_err", proto_err, 1'b0);

        // 4: fairness, both held for 16 back-to-back transactions
        do_reset();
        mem_lat = 1;
        @(negedge clock);
        bus.req_oe    = 2'b01;
        bus.req_we    = 2'b10;
        bus.req_addr  = {7'h03, 7'h05};
        bus.req_wdata = {8'h77, 8'h00};
        bus.req_size  = {4'd8, 4'd8};
        for (int i = 0; i < 16; i++) begin
            wait_rsp(20, seen, data);
            check("fair_grant", seen, (i % 2 == 1) ? 2'b10 : 2'b01);
            check("fair_data", data, (i % 2 == 1) ? 16'h0000 : 16'h00A5);
        end
        clr_req();
        @(negedge clock);
        @(negedge clock);
`ifdef MEM_ARB_STATS_EN
        check("fair_cnt", grant_cnt, {16'd8, 16'd8});
`else
        check("fair_cnt", grant_cnt, 32'd0);
`endif
        check("fair_no_err", proto_err, 1'b0);
        check("fair_mem_wr", mem_arr[3], 8'h77);

        // 5a: ch1 oe&we -> proto_err, performed as a read
        do_reset();
        check("err_clear", proto_err, 1'b0);
        mem_lat = 1;
        @(negedge clock);
        bus.req_oe   = 2'b10;
        bus.req_we   = 2'b10;
        bus.req_addr = {7'h05, 7'h00};
        bus.req_size = {4'd8, 4'd0};
        @(negedge clock);
        check("both_cmd", {bus.mem_oe, bus.mem_we}, 2'b10);
        check("both_addr", bus.mem_addr, 7'h05);
        check("both_err", proto_err, 1'b1);
        wait_rsp(20, seen, data);
        check("both_rsp", seen, 2'b10);
        check("both_data", data, 16'hA500);
        clr_req();

        // 5b: fresh run, ch0 drops oe during WAIT
        do_reset();
        mem_lat = 3;
        @(negedge clock);
        bus.req_oe   = 2'b01;
        bus.req_addr = {7'd0, 7'h05};
        bus.req_size = {4'd0, 4'd8};
        @(negedge clock);
        check("drop_err_before", proto_err, 1'b0);
        @(negedge clock);
        bus.req_oe = 2'b00;
        @(negedge clock);
        check("drop_state", state_dbg, WAIT);
        check("drop_oe_held", bus.mem_oe, 1'b1);
        check("drop_addr_held", bus.mem_addr, 7'h05);
        check("drop_err", proto_err, 1'b1);
        wait_rsp(20, seen, data);
        check("drop_rsp", seen, 2'b01);
        check("drop_data", data, 16'h00A5);
        clr_req();
        @(negedge clock);
        @(negedge clock);
        check("drop_err_sticky", proto_err, 1'b1);

        // 6: reset during WAIT, then a clean ch1 read
        do_reset();
        mem_lat = 5;
        @(negedge clock);
        bus.req_oe   = 2'b01;
        bus.req_addr = {7'd0, 7'h05};
        bus.req_size = {4'd0, 4'd8};
        @(negedge clock);
        @(negedge clock);
        @(negedge clock);
        check("midrst_pre_state", state_dbg, WAIT);
        #2 reset = 1'b0;
        #1;
        check("midrst_mem", {bus.mem_oe, bus.mem_we}, 2'b00);
        check("midrst_rsp", bus.rsp_rdy, 2'b00);
        check("midrst_state", state_dbg, IDLE);
        clr_req();
        @(negedge clock);
        #2 reset = 1'b1;
        mem_lat = 1;
        @(negedge clock);
        bus.req_oe   = 2'b10;
        bus.req_addr = {7'h02, 7'h00};
        bus.req_size = {4'd8, 4'd0};
        wait_rsp(20, seen, data);
        check("post_rsp", seen, 2'b10);
        check("post_data", data, 16'h3C00);
        check("post_err", proto_err, 1'b0);
        clr_req();
        @(negedge clock);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
